// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory arbiter
// Contents: sequencer state enum, default widths, port ids, port->one-hot helper.
package dmem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 6;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT_DMA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant with last-grant memory
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-port request
//   update     : grant was consumed this cycle; remember the winner
//   gnt        : one-hot (or zero) grant, purely combinational from req
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // Tie goes to the port that did not win last time.
      2'b11:   gnt = (last_grant == PORT_DMA) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Resets to the DMA port so the CPU port wins the very first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= PORT_DMA;
    end else if (update) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and access sequencer for the data memory
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-port request handshake
//   req_we/adr/wdat       : per-port request payload (word address)
//   rsp_valid/err/rdat    : one-cycle response to the granted port
//   mem_adr/wdat/R/W      : memory address, write data and level strobes
//   mem_rdat              : combinational read data from the memory
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [1:0][31:0]      req_adr,
  input  logic [1:0][DATA_W-1:0] req_wdat,
  output logic [1:0]            rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_W-1:0]     rsp_rdat,
  output logic [31:0]           mem_adr,
  output logic [DATA_W-1:0]     mem_wdat,
  output logic                  mem_R,
  output logic                  mem_W,
  input  logic [DATA_W-1:0]     mem_rdat
);

  state_t            state_q, state_d;
  logic [1:0]        gnt;
  logic              grant_take;
  logic              port_q;
  logic              we_q;
  logic [31:0]       adr_q;
  logic [DATA_W-1:0] wdat_q;
  logic              err_q;
  logic [DATA_W-1:0] rdat_q;
  logic              in_range;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .update (grant_take),
    .gnt    (gnt)
  );

  assign in_range   = (adr_q[31:ADDR_W] == '0);
  assign grant_take = (state_q == IDLE) && (gnt != 2'b00);

  // Latched request drives the memory bus and simply holds outside ACCESS.
  assign mem_adr  = adr_q;
  assign mem_wdat = wdat_q;
  assign rsp_rdat = rdat_q;

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    mem_R     = 1'b0;
    mem_W     = 1'b0;
    rsp_valid = 2'b00;
    rsp_err   = 1'b0;
    case (state_q)
      IDLE: begin
        // gnt is only non-zero for a valid port, so ready never leads valid.
        req_ready = gnt;
        if (gnt != 2'b00) state_d = ACCESS;
      end
      ACCESS: begin
        // Strobes are decoded from state so an async reset kills them at once.
        mem_R   = in_range && !we_q;
        mem_W   = in_range && we_q;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = port_onehot(port_q);
        rsp_err   = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      port_q  <= PORT_CPU;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (grant_take) begin
        port_q <= gnt[1];
        we_q   <= req_we[gnt[1]];
        adr_q  <= req_adr[gnt[1]];
        wdat_q <= req_wdat[gnt[1]];
      end
      if (state_q == ACCESS) begin
        err_q  <= !in_range;
        // Writes and rejected accesses report zero rather than bus noise.
        rdat_q <= (in_range && !we_q) ? mem_rdat : '0;
      end
    end
  end

endmodule
